// File: rtl/npu_act_pkg.sv
// Shared types for the NPU activation stream: activation selectors and the
// sequencer FSM encoding.
package npu_act_pkg;

  localparam int ACT_TYPE_W = 4;
  localparam int Q_FRAC     = 24;

  typedef enum logic [ACT_TYPE_W-1:0] {
    RELU    = 4'd0,
    PRELU   = 4'd1,
    SILU    = 4'd2,
    GELU    = 4'd3,
    SIGMOID = 4'd4,
    TANH    = 4'd5,
    SWISH   = 4'd6,
    PASS    = 4'd15
  } act_type_e;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } seq_state_e;

endpackage

// File: rtl/npu_sync_fifo.sv
// Show-ahead synchronous FIFO; head word is always visible on rdata_o.
// Push and pop together on a full or empty FIFO keep the count unchanged.
module npu_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [WIDTH-1:0]       wdata_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_push = push_i && (!full_o || pop_i);
  assign do_pop  = pop_i && (!empty_o || push_i);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; emptiness is tracked by count_q alone.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/act_stream_sequencer.sv
// Job sequencer: feeds MAC words into the fixed-latency activation pipe and
// collects results in a local FIFO, using credits so the pipe never stalls.
module act_stream_sequencer
  import npu_act_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int PIPE_LAT   = 5,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic [ACT_TYPE_W-1:0] act_type_cfg_i,
  input  logic [LEN_WIDTH-1:0]  len_i,
  input  logic                  in_valid_i,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  output logic                  in_ready_o,
  output logic                  act_valid_o,
  output logic [DATA_WIDTH-1:0] act_data_o,
  output logic [ACT_TYPE_W-1:0] act_type_o,
  input  logic                  res_valid_i,
  input  logic [DATA_WIDTH-1:0] res_data_i,
  output logic                  out_valid_o,
  output logic [DATA_WIDTH-1:0] out_data_o,
  input  logic                  out_ready_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o
);

  localparam int CRED_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(FIFO_DEPTH);

  if (FIFO_DEPTH < PIPE_LAT) begin : g_depth_chk
    $error("FIFO_DEPTH must be at least PIPE_LAT");
  end

  seq_state_e            state_q, state_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d, issued_q, issued_d, recv_q, recv_d;
  logic [ACT_TYPE_W-1:0] type_q, type_d, act_type_q, act_type_d;
  logic [CRED_W-1:0]     credits_q, credits_d;
  logic                  err_q, err_d, armed_q, armed_d, done_q, done_d;
  logic                  act_valid_q, act_valid_d;
  logic [DATA_WIDTH-1:0] act_data_q, act_data_d;

  logic                  accept, pop, push, outstanding;
  logic [DATA_WIDTH-1:0] fifo_rdata;
  logic                  fifo_full, fifo_empty;
  logic [CRED_W-1:0]     fifo_count;

  assign in_ready_o  = (state_q == RUN) && (credits_q != '0) && (issued_q < len_q);
  assign accept      = in_valid_i && in_ready_o;
  assign pop         = !fifo_empty && out_ready_i;
  assign outstanding = (recv_q != issued_q);
  assign push        = res_valid_i && outstanding && !fifo_full;

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    type_d      = type_q;
    issued_d    = issued_q;
    recv_d      = recv_q;
    credits_d   = credits_q;
    err_d       = err_q;
    armed_d     = armed_q;
    act_valid_d = 1'b0;
    act_data_d  = act_data_q;
    act_type_d  = act_type_q;
    done_d      = 1'b0;

    if (accept) begin
      act_valid_d = 1'b1;
      act_data_d  = in_data_i;
      act_type_d  = type_q;
      issued_d    = issued_q + LEN_WIDTH'(1);
    end

    // A result with nothing outstanding is dropped; it only counts as an
    // error once a job has been started since reset.
    if (push) begin
      recv_d = recv_q + LEN_WIDTH'(1);
    end else if (res_valid_i && !outstanding && armed_q) begin
      err_d = 1'b1;
    end

    case ({accept, pop})
      2'b10:   credits_d = credits_q - CRED_W'(1);
      2'b01:   if (credits_q != CRED_MAX) credits_d = credits_q + CRED_W'(1);
      default: credits_d = credits_q;
    endcase

    case (state_q)
      IDLE: begin
        if (start_i) begin
          len_d    = len_i;
          type_d   = act_type_cfg_i;
          err_d    = 1'b0;
          armed_d  = 1'b1;
          issued_d = '0;
          recv_d   = '0;
          state_d  = (len_i == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (accept && (issued_d == len_q)) state_d = DRAIN;
      end
      DRAIN: begin
        if ((recv_q == len_q) && (fifo_count == '0)) state_d = DONE;
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      len_q       <= '0;
      type_q      <= '0;
      issued_q    <= '0;
      recv_q      <= '0;
      credits_q   <= CRED_MAX;
      err_q       <= 1'b0;
      armed_q     <= 1'b0;
      done_q      <= 1'b0;
      act_valid_q <= 1'b0;
      act_data_q  <= '0;
      act_type_q  <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      type_q      <= type_d;
      issued_q    <= issued_d;
      recv_q      <= recv_d;
      credits_q   <= credits_d;
      err_q       <= err_d;
      armed_q     <= armed_d;
      done_q      <= done_d;
      act_valid_q <= act_valid_d;
      act_data_q  <= act_data_d;
      act_type_q  <= act_type_d;
    end
  end

  npu_sync_fifo #(
    .WIDTH(DATA_WIDTH),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push_i (push),
    .pop_i  (pop),
    .wdata_i(res_data_i),
    .rdata_o(fifo_rdata),
    .full_o (fifo_full),
    .empty_o(fifo_empty),
    .count_o(fifo_count)
  );

  assign act_valid_o = act_valid_q;
  assign act_data_o  = act_data_q;
  assign act_type_o  = act_type_q;
  assign out_valid_o = !fifo_empty;
  assign out_data_o  = fifo_empty ? '0 : fifo_rdata;
  assign busy_o      = (state_q == RUN) || (state_q == DRAIN);
  assign done_o      = done_q;
  assign err_o       = err_q;

endmodule
